// File: rtl/ws2812_pkg.sv
// Shared constants and sizing helpers for the WS2812 multi-LED fader.
package ws2812_pkg;

    // Byte position of each colour within one LED's group of bytes
    localparam int CH_R = 0;
    localparam int CH_G = 1;
    localparam int CH_B = 2;
    localparam int CH_W = 3;

    // Number of stored milestones: one per INTERPOLATIONS LEDs plus the trailing one
    function automatic int milestones(input int leds, input int interp);
        return (leds + interp - 1) / interp + 1;
    endfunction

endpackage

// File: rtl/ws2812_if.sv
// Handshake between the fader (master) and the WS2812 bit serializer (slave).
interface ws2812_if;
    logic       data_request;
    logic       trigger;
    logic [7:0] color_now;
    logic       frame_done;

    modport master (input data_request, output trigger, output color_now, output frame_done);
    modport slave  (output data_request, input trigger, input color_now, input frame_done);
endinterface

// File: rtl/ws2812_lerp.sv
// Blends two milestone bytes at interpolation step k, then applies global brightness.
module ws2812_lerp #(
    parameter int INTERPOLATIONS = 8,
    parameter int KW             = $clog2(INTERPOLATIONS)
) (
    input  logic [7:0]    i_next,
    input  logic [7:0]    i_prev,
    input  logic [KW-1:0] i_k,
    input  logic [7:0]    i_brightness,
    output logic [7:0]    o_byte
);
    // Weighted sum peaks at 255*INTERPOLATIONS; one spare bit keeps the subtraction safe
    localparam int SW = 9 + KW;

    logic [SW-1:0] w_sum;
    logic [7:0]    w_lerp;
    logic [15:0]   w_scaled;

    assign w_sum    = SW'(i_next) * (SW'(INTERPOLATIONS) - SW'(i_k)) + SW'(i_prev) * SW'(i_k);
    // INTERPOLATIONS is a power of two, so the divide is a shift
    assign w_lerp   = 8'(w_sum >> KW);
    // (v * (b+1)) >> 8 lets brightness 255 pass the value through untouched
    assign w_scaled = {8'b0, w_lerp} * ({8'b0, i_brightness} + 16'd1);
    assign o_byte   = 8'(w_scaled >> 8);
endmodule

// File: rtl/ws2812_multi_fader.sv
// Produces a per-byte colour stream for a WS2812 chain: random milestones spaced
// INTERPOLATIONS LEDs apart, linearly blended, slowly scrolled frame by frame.
module ws2812_multi_fader
    import ws2812_pkg::*;
#(
    parameter int LEDS           = 32,
    parameter int INTERPOLATIONS = 8,
    parameter int CHANNELS       = 3,
    parameter int RANDBITS       = 5,
    parameter int HOLDOFF_TIME   = 800000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [CHANNELS*RANDBITS-1:0] random,
    input  logic [7:0]                   brightness,
    input  logic                         direction,
    input  logic                         freeze,
    ws2812_if.master                     bus
);
    localparam int MS   = milestones(LEDS, INTERPOLATIONS);
    localparam int LOGI = $clog2(INTERPOLATIONS);
    localparam int LW   = (LEDS > 1) ? $clog2(LEDS) : 1;
    localparam int CW   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int MW   = $clog2(MS);
    localparam int TW   = $clog2(LEDS + INTERPOLATIONS);
    localparam int HW   = $clog2(HOLDOFF_TIME + 2);

    logic [MS-1:0][CHANNELS-1:0][7:0] r_ms;
    logic [HW-1:0]                    r_hold;
    logic [CW-1:0]                    r_chan;
    logic [LW-1:0]                    r_led;
    logic [LOGI-1:0]                  r_start;
    logic                             r_dir;
    logic                             r_done;

    logic                             w_at_start;
    logic                             w_dir;
    logic [LW-1:0]                    w_led_log;
    logic [TW-1:0]                    w_total;
    logic [TW-1:0]                    w_m;
    logic                             w_m_last;
    logic [MW-1:0]                    w_mn;
    logic [MW-1:0]                    w_mp;
    logic [CHANNELS-1:0][7:0]         w_new;
    logic [7:0]                       w_byte;

    // Direction is live on the very first byte and latched for the rest of the frame
    assign w_at_start = (r_led == '0) && (r_chan == '0);
    assign w_dir      = w_at_start ? direction : r_dir;
    assign w_led_log  = w_dir ? (LW'(LEDS - 1) - r_led) : r_led;

    // Position along the milestone chain: low bits are the step k, high bits the milestone
    assign w_total  = TW'(r_start) + TW'(w_led_log);
    assign w_m      = w_total >> LOGI;
    assign w_m_last = (w_m >= TW'(MS - 1));
    // Clamp the blend partner to the last stored milestone for long tails
    assign w_mn     = w_m_last ? MW'(MS - 1) : MW'(w_m);
    assign w_mp     = w_m_last ? MW'(MS - 1) : MW'(w_m + TW'(1));

    // New milestone: RANDBITS of entropy per channel, left-justified in the byte
    always_comb begin
        w_new = '0;
        for (int c = 0; c < CHANNELS; c++)
            w_new[c] = 8'({random[c*RANDBITS +: RANDBITS], 8'b0} >> RANDBITS);
    end

    ws2812_lerp #(.INTERPOLATIONS(INTERPOLATIONS), .KW(LOGI)) u_lerp (
        .i_next       (r_ms[w_mn][r_chan]),
        .i_prev       (r_ms[w_mp][r_chan]),
        .i_k          (w_total[LOGI-1:0]),
        .i_brightness (brightness),
        .o_byte       (w_byte)
    );

    assign bus.color_now  = w_byte;
    assign bus.trigger    = (r_hold == '0);
    assign bus.frame_done = r_done;

    // Byte walker, frame-end holdoff and milestone scroll
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ms    <= '0;
            r_hold  <= '0;
            r_chan  <= '0;
            r_led   <= '0;
            r_start <= '0;
            r_dir   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_hold != '0) begin
                r_hold <= r_hold - HW'(1);
            end else if (bus.data_request) begin
                if (w_at_start)
                    r_dir <= direction;
                if (r_chan == CW'(CHANNELS - 1)) begin
                    r_chan <= '0;
                    if (r_led == LW'(LEDS - 1)) begin
                        r_led  <= '0;
                        r_hold <= HW'(HOLDOFF_TIME);
                        r_done <= 1'b1;
                        if (!freeze) begin
                            if (r_start != '0) begin
                                r_start <= r_start - LOGI'(1);
                            end else begin
                                r_start <= LOGI'(INTERPOLATIONS - 1);
                                r_ms    <= {r_ms[MS-2:0], w_new};
                            end
                        end
                    end else begin
                        r_led <= r_led + LW'(1);
                    end
                end else begin
                    r_chan <= r_chan + CW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_ws2812_multi_fader.sv
// Directed bench for ws2812_multi_fader with LEDS=4, INTERPOLATIONS=2, CHANNELS=3, RANDBITS=5.
module tb_ws2812_multi_fader;
    localparam int LEDS   = 4;
    localparam int INTERP = 2;
    localparam int CH     = 3;
    localparam int RB     = 5;
    localparam int HOLD   = 10;
    localparam int NB     = LEDS * CH;

    typedef logic [7:0] frm_t [NB];

    logic             clk    = 1'b0;
    logic             rst    = 1'b0;
    logic [CH*RB-1:0] rnd    = '0;
    logic [7:0]       bright = 8'hFF;
    logic             dir    = 1'b0;
    logic             frz    = 1'b0;

    int   n_tests = 0;
    int   n_fail  = 0;
    frm_t fb;

    // A: ch0=31 (F8) ch1=16 (80) ch2=8 (40); B: ch0=4 (20) ch1=0 (00) ch2=31 (F8)
    localparam logic [CH*RB-1:0] RND_A = {5'd8, 5'd16, 5'd31};
    localparam logic [CH*RB-1:0] RND_B = {5'd31, 5'd0, 5'd4};

    ws2812_if bus ();

    ws2812_multi_fader #(
        .LEDS(LEDS), .INTERPOLATIONS(INTERP), .CHANNELS(CH),
        .RANDBITS(RB), .HOLDOFF_TIME(HOLD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .random     (rnd),
        .brightness (bright),
        .direction  (dir),
        .freeze     (frz),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // n back-to-back requests; byte sampled mid-cycle; direction flipped before request tog_at
    task automatic do_reqs(input int n, input int tog_at);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == tog_at) dir = ~dir;
            bus.data_request = 1'b1;
            #1 fb[i] = bus.color_now;
            @(posedge clk);
            #1 bus.data_request = 1'b0;
        end
    endtask

    task automatic wait_trig(output int n);
        n = 0;
        while (bus.trigger !== 1'b1 && n < 100) begin
            @(posedge clk);
            #1 n++;
        end
        chk("trigger_back", bus.trigger, 1);
    endtask

    task automatic run_frame(input int tog_at);
        int n;
        do_reqs(NB, tog_at);
        wait_trig(n);
    endtask

    task automatic cmp_frame(input string tag, input frm_t e);
        for (int i = 0; i < NB; i++)
            chk($sformatf("%s[%0d]", tag, i), fb[i], e[i]);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        frm_t e;
        int   n;
        bus.data_request = 1'b0;

        // Reset state
        do_reset();
        #1;
        chk("rst_trigger", bus.trigger, 1);
        chk("rst_color", bus.color_now, 0);
        chk("rst_done", bus.frame_done, 0);

        // First frame all zero, single done pulse, 10-cycle holdoff
        do_reqs(NB, -1);
        for (int i = 0; i < NB; i++) e[i] = 8'h00;
        cmp_frame("zero", e);
        chk("done_pulse", bus.frame_done, 1);
        chk("trig_busy", bus.trigger, 0);
        @(posedge clk);
        #1 chk("done_once", bus.frame_done, 0);
        n = 1;
        while (bus.trigger !== 1'b1 && n < 100) begin
            @(posedge clk);
            #1 n++;
        end
        chk("holdoff_len", n, HOLD);

        // Saturated random fills every milestone with F8 after five frame ends
        do_reset();
        rnd = '1;
        repeat (5) run_frame(-1);
        run_frame(-1);
        for (int i = 0; i < NB; i++) e[i] = 8'hF8;
        cmp_frame("full", e);
        bright = 8'd127;
        run_frame(-1);
        for (int i = 0; i < NB; i++) e[i] = 8'h7C;
        cmp_frame("dim", e);
        bright = 8'hFF;

        // One inserted milestone, k=1 against zero; requests in holdoff are dropped
        do_reset();
        rnd = '1;
        do_reqs(NB, -1);
        do_reqs(3, -1);
        chk("hold_trig", bus.trigger, 0);
        wait_trig(n);
        run_frame(-1);
        e = '{8'h7C, 8'h7C, 8'h7C, 8'h00, 8'h00, 8'h00,
              8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        cmp_frame("step", e);

        // Milestones [B,A,0] at start=1, then freeze and scroll
        do_reset();
        rnd = RND_A;
        run_frame(-1);
        rnd = RND_B;
        run_frame(-1);
        run_frame(-1);
        frz = 1'b1;
        run_frame(-1);
        e = '{8'h8C, 8'h40, 8'h9C, 8'hF8, 8'h80, 8'h40,
              8'h7C, 8'h40, 8'h20, 8'h00, 8'h00, 8'h00};
        cmp_frame("frz_a", e);
        frz = 1'b0;
        run_frame(-1);
        cmp_frame("frz_b", e);
        frz = 1'b1;
        run_frame(-1);
        e = '{8'h20, 8'h00, 8'hF8, 8'h8C, 8'h40, 8'h9C,
              8'hF8, 8'h80, 8'h40, 8'h7C, 8'h40, 8'h20};
        cmp_frame("shift", e);

        // Reversed LED order, mid-frame direction flips ignored
        dir = 1'b1;
        run_frame(5);
        e = '{8'h7C, 8'h40, 8'h20, 8'hF8, 8'h80, 8'h40,
              8'h8C, 8'h40, 8'h9C, 8'h20, 8'h00, 8'hF8};
        cmp_frame("rev", e);
        dir = 1'b0;
        run_frame(5);
        e = '{8'h20, 8'h00, 8'hF8, 8'h8C, 8'h40, 8'h9C,
              8'hF8, 8'h80, 8'h40, 8'h7C, 8'h40, 8'h20};
        cmp_frame("fwd", e);
        dir = 1'b0;

        // Reset mid-frame abandons the frame and clears milestones
        do_reqs(5, -1);
        frz = 1'b0;
        do_reset();
        #1;
        chk("mid_rst_trig", bus.trigger, 1);
        chk("mid_rst_color", bus.color_now, 0);
        rnd = RND_A;
        run_frame(-1);
        chk("mid_rst_first", fb[0], 0);
        run_frame(-1);
        e = '{8'h7C, 8'h40, 8'h20, 8'h00, 8'h00, 8'h00,
              8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        cmp_frame("post_rst", e);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
